// File: rtl/sys_info_pkg.sv
// sys_info_pkg: word map, STATUS bit indices and CAPS layout shared by the sys_info slave
package sys_info_pkg;
  localparam logic [2:0] ADDR_ID      = 3'd0;
  localparam logic [2:0] ADDR_TS      = 3'd1;
  localparam logic [2:0] ADDR_UP_LO   = 3'd2;
  localparam logic [2:0] ADDR_UP_HI   = 3'd3;
  localparam logic [2:0] ADDR_SCRATCH = 3'd4;
  localparam logic [2:0] ADDR_CAPS    = 3'd5;
  localparam logic [2:0] ADDR_STATUS  = 3'd6;
  localparam logic [2:0] ADDR_RSVD    = 3'd7;
  localparam int ST_WRAP  = 0;
  localparam int ST_RO_WR = 1;
  localparam int CAPS_LAT_LSB = 0;
  localparam int CAPS_W_LSB   = 4;
  localparam int CAPS_PRESENT = 31;
  function automatic logic [31:0] caps_word(input int lat, input int w, input logic present);
    logic [31:0] c;
    c = '0;
    c[CAPS_LAT_LSB+:4] = 4'(lat);
    c[CAPS_W_LSB+:7] = present ? 7'(w) : 7'd0;
    c[CAPS_PRESENT] = present;
    return c;
  endfunction
endpackage

// File: rtl/sys_info_rd_pipe.sv
// sys_info_rd_pipe: fixed-depth valid/data shift pipeline for read responses, flushed by reset
module sys_info_rd_pipe #(
  parameter int DEPTH = 1,
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);
  logic [DEPTH-1:0] v;
  logic [W-1:0] d [DEPTH];
  // shift responses toward the output; data is zeroed in bubbles so the output is 0 whenever invalid
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++) d[i] <= '0;
    end else begin
      v[0] <= in_valid;
      d[0] <= in_valid ? in_data : '0;
      for (int i = 1; i < DEPTH; i++) begin
        v[i] <= v[i-1];
        d[i] <= d[i-1];
      end
    end
  end
  assign out_valid = v[DEPTH-1];
  assign out_data = d[DEPTH-1];
endmodule

// File: rtl/rangefinder_sopc_sys_info.sv
// rangefinder_sopc_sys_info: Avalon-MM build ID/uptime/scratch/status slave; define SYS_INFO_UPTIME_EN to build the uptime counter
module rangefinder_sopc_sys_info
  import sys_info_pkg::*;
#(
  parameter logic [31:0] SYSTEM_ID = 32'h1312_AB79,
  parameter logic [31:0] TIMESTAMP = 32'h5000_0000,
  parameter int UPTIME_W = 48,
  parameter int READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);
  logic rd_acc, ro_wr, wrap_set;
  logic [1:0] status, set, clr;
  logic [31:0] scratch, up_lo, up_hi, rd_data;
  assign rd_acc = read && !write;
  assign ro_wr = write && address != ADDR_SCRATCH && address != ADDR_STATUS;
  assign clr = (write && address == ADDR_STATUS && byteenable[0]) ? writedata[1:0] : 2'b00;
`ifdef SYS_INFO_UPTIME_EN
  localparam logic PRESENT = 1'b1;
  logic [UPTIME_W-1:0] uptime;
  logic [UPTIME_W-33:0] shadow;
  // free-running uptime; an accepted LO read snapshots the upper bits so the following HI read is coherent
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      uptime <= '0;
      shadow <= '0;
    end else begin
      uptime <= uptime + UPTIME_W'(1);
      if (rd_acc && address == ADDR_UP_LO) shadow <= uptime[UPTIME_W-1:32];
    end
  end
  assign up_lo = uptime[31:0];
  assign up_hi = 32'(shadow);
  assign wrap_set = &uptime;
`else
  localparam logic PRESENT = 1'b0;
  assign up_lo = '0;
  assign up_hi = '0;
  assign wrap_set = 1'b0;
`endif
  localparam logic [31:0] CAPS = caps_word(READ_LATENCY, UPTIME_W, PRESENT);
  // sticky status event sources
  always_comb begin
    set = '0;
    set[ST_WRAP] = wrap_set;
    set[ST_RO_WR] = ro_wr;
  end
  // word-map read mux, sampled in the accept cycle
  always_comb begin
    case (address)
      ADDR_ID:      rd_data = SYSTEM_ID;
      ADDR_TS:      rd_data = TIMESTAMP;
      ADDR_UP_LO:   rd_data = up_lo;
      ADDR_UP_HI:   rd_data = up_hi;
      ADDR_SCRATCH: rd_data = scratch;
      ADDR_CAPS:    rd_data = CAPS;
      ADDR_STATUS:  rd_data = 32'(status);
      default:      rd_data = '0;
    endcase
  end
  // byte-enabled scratch and W1C status where a same-cycle set beats the clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scratch <= '0;
      status <= '0;
    end else begin
      if (write && address == ADDR_SCRATCH)
        for (int i = 0; i < 4; i++) if (byteenable[i]) scratch[8*i+:8] <= writedata[8*i+:8];
      status <= (status & ~clr) | set;
    end
  end
  sys_info_rd_pipe #(.DEPTH(READ_LATENCY), .W(32)) u_rd_pipe (
    .clock(clock),
    .reset_n(reset_n),
    .in_valid(rd_acc),
    .in_data(rd_data),
    .out_valid(readdatavalid),
    .out_data(readdata)
  );
endmodule

// File: tb/tb_rangefinder_sopc_sys_info.sv
// tb_rangefinder_sopc_sys_info: table, directed and random checks of the sys_info slave against a spec-level model
module tb_rangefinder_sopc_sys_info;
  localparam int LAT = 3;
  localparam int UW = 48;
  localparam logic [31:0] ID = 32'h1312_AB79;
  localparam logic [31:0] TS = 32'h5000_0000;
  localparam longint unsigned UP_MASK = (64'd1 << UW) - 64'd1;
`ifdef SYS_INFO_UPTIME_EN
  localparam bit UP_EN = 1'b1;
  localparam logic [31:0] CAPS_EXP = 32'h8000_0303;
`else
  localparam bit UP_EN = 1'b0;
  localparam logic [31:0] CAPS_EXP = 32'h0000_0003;
`endif
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [2:0] address = '0;
  logic read = 1'b0, write = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0] byteenable = '0;
  logic [31:0] readdata;
  logic readdatavalid;
  always #5 clock = ~clock;
  rangefinder_sopc_sys_info #(.SYSTEM_ID(ID), .TIMESTAMP(TS), .UPTIME_W(UW), .READ_LATENCY(LAT)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .address(address),
    .read(read),
    .write(write),
    .writedata(writedata),
    .byteenable(byteenable),
    .readdata(readdata),
    .readdatavalid(readdatavalid)
  );
  typedef struct {
    logic [31:0] d;
    int due;
  } rsp_t;
  typedef struct {
    logic rd;
    logic wr;
    logic [2:0] a;
    logic [31:0] wd;
    logic [3:0] be;
    logic [31:0] exp;
  } vec_t;
  rsp_t q[$];
  vec_t tbl[$];
  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  longint unsigned m_up, m_shadow;
  logic [31:0] m_scratch;
  logic [1:0] m_status;
  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0: return ID;
      3'd1: return TS;
      3'd2: return UP_EN ? m_up[31:0] : 32'd0;
      3'd3: return UP_EN ? m_shadow[31:0] : 32'd0;
      3'd4: return m_scratch;
      3'd5: return CAPS_EXP;
      3'd6: return {30'd0, m_status};
      default: return 32'd0;
    endcase
  endfunction
  task automatic model_step(input logic rd, input logic wr, input logic [2:0] a, input logic [31:0] wd, input logic [3:0] be);
    logic [1:0] s, c;
    s[0] = UP_EN && (m_up == UP_MASK);
    s[1] = wr && a != 3'd4 && a != 3'd6;
    c = (wr && a == 3'd6 && be[0]) ? wd[1:0] : 2'b00;
    if (wr && a == 3'd4)
      for (int i = 0; i < 4; i++) if (be[i]) m_scratch[8*i+:8] = wd[8*i+:8];
    if (rd && !wr && a == 3'd2) m_shadow = m_up >> 32;
    m_status = (m_status & ~c) | s;
    m_up = (m_up + 64'd1) & UP_MASK;
  endtask
  task automatic check_out();
    logic ev;
    logic [31:0] ed;
    ev = 1'b0;
    ed = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      ev = 1'b1;
      ed = q[0].d;
      void'(q.pop_front());
    end
    n_vec++;
    if (readdatavalid !== ev || readdata !== ed) begin
      n_err++;
      $display("FAIL rsp cyc=%0d: got valid=%0b data=%h, expected valid=%0b data=%h", cyc, readdatavalid, readdata, ev, ed);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    cyc++;
    @(negedge clock);
    check_out();
  endtask
  task automatic cycle(input logic rd, input logic wr, input logic [2:0] a, input logic [31:0] wd, input logic [3:0] be, input logic [31:0] exp);
    read = rd;
    write = wr;
    address = a;
    writedata = wd;
    byteenable = be;
    if (rd && !wr) q.push_back('{exp, cyc + LAT});
    model_step(rd, wr, a, wd, be);
    tick();
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 3'd0, 32'd0, 4'd0, 32'd0);
  endtask
  task automatic do_reset();
    read = 1'b0;
    write = 1'b0;
    reset_n = 1'b0;
    q.delete();
    m_up = 0;
    m_shadow = 0;
    m_scratch = '0;
    m_status = '0;
    #1 check_out();
    repeat (2) tick();
    reset_n = 1'b1;
  endtask
`ifdef SYS_INFO_UPTIME_EN
  task automatic set_up(input longint unsigned v);
    force dut.uptime = UW'(v);
    #1 release dut.uptime;
    m_up = v;
  endtask
`endif
  initial begin
    tbl.push_back('{1'b1, 1'b0, 3'd0, 32'h0, 4'h0, ID});
    tbl.push_back('{1'b1, 1'b0, 3'd1, 32'h0, 4'h0, TS});
    tbl.push_back('{1'b1, 1'b0, 3'd5, 32'h0, 4'h0, CAPS_EXP});
    tbl.push_back('{1'b1, 1'b0, 3'd4, 32'h0, 4'h0, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 3'd4, 32'hDEAD_BEEF, 4'b0101, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 3'd4, 32'h0, 4'h0, 32'h00AD_00EF});
    tbl.push_back('{1'b1, 1'b0, 3'd6, 32'h0, 4'h0, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 3'd0, 32'h1234_5678, 4'hF, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 3'd0, 32'h0, 4'h0, ID});
    tbl.push_back('{1'b1, 1'b0, 3'd6, 32'h0, 4'h0, 32'h2});
    tbl.push_back('{1'b0, 1'b1, 3'd6, 32'h2, 4'h1, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 3'd6, 32'h0, 4'h0, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 3'd7, 32'hFFFF_FFFF, 4'hF, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 3'd6, 32'h0, 4'h0, 32'h2});
    tbl.push_back('{1'b1, 1'b0, 3'd7, 32'h0, 4'h0, 32'h0});
    tbl.push_back('{1'b1, 1'b1, 3'd4, 32'hCAFE_F00D, 4'hF, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 3'd4, 32'h0, 4'h0, 32'hCAFE_F00D});
    tbl.push_back('{1'b0, 1'b1, 3'd6, 32'h3, 4'hF, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 3'd3, 32'h5, 4'hF, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 3'd6, 32'h0, 4'h0, 32'h2});
    @(negedge clock);
    do_reset();
    foreach (tbl[i]) cycle(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].be, tbl[i].exp);
    idle(LAT);
    for (int a = 0; a < 8; a++) cycle(1'b1, 1'b0, 3'(a), 32'd0, 4'd0, model_read(3'(a)));
    idle(LAT);
    cycle(1'b1, 1'b0, 3'd0, 32'd0, 4'd0, ID);
    cycle(1'b1, 1'b0, 3'd1, 32'd0, 4'd0, TS);
    do_reset();
    idle(6);
`ifdef SYS_INFO_UPTIME_EN
    cycle(1'b0, 1'b1, 3'd6, 32'h3, 4'hF, 32'd0);
    set_up(64'h0000_FFFF_FFFF);
    cycle(1'b1, 1'b0, 3'd2, 32'd0, 4'd0, 32'hFFFF_FFFF);
    cycle(1'b1, 1'b0, 3'd3, 32'd0, 4'd0, 32'h0000_0000);
    cycle(1'b1, 1'b0, 3'd2, 32'd0, 4'd0, 32'h0000_0001);
    cycle(1'b1, 1'b0, 3'd3, 32'd0, 4'd0, 32'h0000_0001);
    idle(LAT);
    set_up(UP_MASK - 64'd2);
    idle(2);
    cycle(1'b0, 1'b1, 3'd6, 32'h1, 4'hF, 32'd0);
    cycle(1'b1, 1'b0, 3'd6, 32'd0, 4'd0, 32'h1);
    cycle(1'b0, 1'b1, 3'd6, 32'h1, 4'hF, 32'd0);
    cycle(1'b1, 1'b0, 3'd6, 32'd0, 4'd0, 32'h0);
    idle(LAT);
`endif
    for (int i = 0; i < 400; i++) begin
      logic [1:0] op;
      logic [2:0] a;
      op = 2'($urandom_range(0, 3));
      a = 3'($urandom_range(0, 7));
      cycle(op[0], op[1], a, $urandom, 4'($urandom_range(0, 15)), model_read(a));
    end
    idle(LAT + 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
